// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART sample framer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN  = 3'd2,
    ST_HI   = 3'd3,
    ST_LO   = 3'd4,
    ST_CSUM = 3'd5
  } state_e;

  typedef enum logic {
    PH_ISSUE = 1'b0,
    PH_WAIT  = 1'b1
  } phase_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_frame_tx_if.sv
// Byte handshake between the framer (master) and the UART transmitter (slave).
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_active;
  logic       tx_done;

  modport master (output tx_start, output tx_data, input tx_active, input tx_done);
  modport slave  (input tx_start, input tx_data, output tx_active, output tx_done);
endinterface

// File: rtl/uart_frame_tx_sync_fifo.sv
// First-word-fall-through sample FIFO; a push while full is taken only if a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok_s, pop_ok_s;

  assign empty_o   = (level_q == LW'(0));
  assign full_o    = (level_q == LW'(DEPTH));
  assign pop_ok_s  = pop_i && !empty_o;
  assign push_ok_s = push_i && (!full_o || pop_ok_s);
  assign dout_o    = mem_q[rptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok_s) begin
        wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? AW'(0) : wptr_q + AW'(1);
      end
      if (pop_ok_s) begin
        rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? AW'(0) : rptr_q + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Packs buffered samples into sync/len/hi-lo/checksum frames and feeds them
// to the UART transmitter one byte at a time.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int         SAMPLE_W   = 12,
  parameter int         FRAME_LEN  = 16,
  parameter int         FIFO_DEPTH = 32,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  localparam int        LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                smp_valid_i,
  input  logic [SAMPLE_W-1:0] smp_data_i,
  input  logic                clr_ovf_i,
  uart_tx_if.master           tx_if,
  output logic                frame_sent_o,
  output logic                overflow_o,
  output logic [LW-1:0]       fifo_level_o
);

  state_e              state_q;
  phase_e              phase_q;
  logic [7:0]          cnt_q, csum_q, lo_q, tx_data_q;
  logic                tx_start_q, frame_sent_q, overflow_q;
  logic [SAMPLE_W-1:0] fifo_dout_s;
  logic                fifo_full_s, fifo_empty_s, pop_s, drop_s;
  logic [LW-1:0]       level_s;
  logic [7:0]          byte_s, hi_s;
  state_e              next_s;

  sync_fifo #(.WIDTH(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (smp_valid_i),
    .pop_i   (pop_s),
    .din_i   (smp_data_i),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (level_s)
  );

  // The head sample leaves the FIFO when its high byte is handed to the transmitter.
  assign pop_s  = (state_q == ST_HI) && (phase_q == PH_ISSUE) && !tx_if.tx_active && !fifo_empty_s;
  assign drop_s = smp_valid_i && fifo_full_s && !pop_s;
  assign hi_s   = 8'(fifo_dout_s >> 8);

  always_comb begin
    byte_s = 8'h00;
    next_s = ST_IDLE;
    case (state_q)
      ST_SYNC: begin byte_s = SYNC_BYTE;     next_s = ST_LEN;  end
      ST_LEN:  begin byte_s = 8'(FRAME_LEN); next_s = ST_HI;   end
      ST_HI:   begin byte_s = hi_s;          next_s = ST_LO;   end
      ST_LO:   begin
        byte_s = lo_q;
        next_s = (cnt_q == 8'(FRAME_LEN - 1)) ? ST_CSUM : ST_HI;
      end
      ST_CSUM: begin byte_s = csum_q;        next_s = ST_IDLE; end
      default: begin byte_s = 8'h00;         next_s = ST_IDLE; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_ISSUE;
      cnt_q        <= 8'h00;
      csum_q       <= 8'h00;
      lo_q         <= 8'h00;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      tx_start_q   <= 1'b0;
      frame_sent_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          csum_q  <= 8'h00;
          cnt_q   <= 8'h00;
          phase_q <= PH_ISSUE;
          if ((level_s >= LW'(FRAME_LEN)) && !tx_if.tx_active) begin
            state_q <= ST_SYNC;
          end
        end
        ST_SYNC, ST_LEN, ST_HI, ST_LO, ST_CSUM: begin
          if (phase_q == PH_ISSUE) begin
            if (!tx_if.tx_active) begin
              tx_start_q <= 1'b1;
              tx_data_q  <= byte_s;
              phase_q    <= PH_WAIT;
              // Sync and the checksum byte itself are excluded from the XOR.
              if (state_q != ST_SYNC && state_q != ST_CSUM) begin
                csum_q <= csum_q ^ byte_s;
              end
              if (state_q == ST_HI) begin
                lo_q <= fifo_dout_s[7:0];
              end
            end
          end else if (tx_if.tx_done) begin
            phase_q <= PH_ISSUE;
            state_q <= next_s;
            if (state_q == ST_LO) begin
              cnt_q <= cnt_q + 8'd1;
            end
            if (state_q == ST_CSUM) begin
              frame_sent_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          phase_q <= PH_ISSUE;
        end
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (drop_s) begin
      overflow_q <= 1'b1;
    end else if (clr_ovf_i) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q;
    end
  end

  assign tx_if.tx_start = tx_start_q;
  assign tx_if.tx_data  = tx_data_q;
  assign frame_sent_o   = frame_sent_q;
  assign overflow_o     = overflow_q;
  assign fifo_level_o   = level_s;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx: two instances (12-bit/len 2/depth 4 and 16-bit/len 1).
module tb_uart_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        va, vb, clra, clrb;
  logic [11:0] da;
  logic [15:0] db;
  logic        fsa, fsb, ova, ovb;
  logic [2:0]  lva, lvb;

  uart_tx_if ifa();
  uart_tx_if ifb();

  uart_frame_tx #(.SAMPLE_W(12), .FRAME_LEN(2), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .smp_valid_i(va), .smp_data_i(da), .clr_ovf_i(clra),
    .tx_if(ifa), .frame_sent_o(fsa), .overflow_o(ova), .fifo_level_o(lva)
  );

  uart_frame_tx #(.SAMPLE_W(16), .FRAME_LEN(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .smp_valid_i(vb), .smp_data_i(db), .clr_ovf_i(clrb),
    .tx_if(ifb), .frame_sent_o(fsb), .overflow_o(ovb), .fifo_level_o(lvb)
  );

  // Transmitter model: busy for 10 cycles after a start, then one done pulse.
  logic [1:0] busy     = 2'b00;
  logic [1:0] mdone    = 2'b00;
  logic [1:0] hold_act = 2'b00;
  int         bcnt [2] = '{0, 0};
  wire  [1:0] st  = {ifb.tx_start, ifa.tx_start};
  wire  [1:0] fs  = {fsb, fsa};

  assign ifa.tx_active = busy[0] | hold_act[0];
  assign ifa.tx_done   = mdone[0];
  assign ifb.tx_active = busy[1] | hold_act[1];
  assign ifb.tx_done   = mdone[1];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mdone[i] <= 1'b0;
      if (bcnt[i] > 0) begin
        bcnt[i] <= bcnt[i] - 1;
        if (bcnt[i] == 1) begin
          mdone[i] <= 1'b1;
          busy[i]  <= 1'b0;
        end
      end else if (st[i]) begin
        busy[i] <= 1'b1;
        bcnt[i] <= 10;
      end
    end
  end

  typedef struct {
    int         dut;
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   last_pend [2] = '{1'b0, 1'b0};
  int   frames [2]    = '{0, 0};

  // Monitor: every start pops one expected byte; every frame_sent must follow a checksum byte.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (st[i]) begin
        n_cmp++;
        if (busy[i]) begin
          n_err++;
          $display("FAIL start_while_busy dut%0d: got tx_start with tx_active=1, required tx_active=0", i);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_start dut%0d: got byte %02h, required no start", i,
                   (i == 0) ? ifa.tx_data : ifb.tx_data);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.dut != i || mon_e.b !== ((i == 0) ? ifa.tx_data : ifb.tx_data)) begin
            n_err++;
            $display("FAIL tx_byte dut%0d: got %02h, required dut%0d byte %02h", i,
                     (i == 0) ? ifa.tx_data : ifb.tx_data, mon_e.dut, mon_e.b);
          end
          last_pend[i] = mon_e.last;
        end
      end
      if (fs[i]) begin
        n_cmp++;
        if (!last_pend[i]) begin
          n_err++;
          $display("FAIL frame_sent dut%0d: got pulse, required none (no checksum byte pending)", i);
        end
        last_pend[i] = 1'b0;
        frames[i]++;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic qf(input int dut, input int n, input logic [7:0] b [7], input bit has_last);
    for (int k = 0; k < n; k++) begin
      sb.push_back('{dut, b[k], has_last && (k == n - 1)});
    end
  endtask

  task automatic push_a(input logic [11:0] d);
    @(negedge clk); va = 1'b1; da = d;
    @(negedge clk); va = 1'b0;
  endtask

  task automatic wait_frames(input int dut, input int n, input int budget);
    int t = 0;
    while (frames[dut] < n && t < budget) begin
      @(negedge clk); t++;
    end
    chk($sformatf("frame_done_dut%0d_n%0d", dut, n), frames[dut], n);
  endtask

  task automatic wait_sb_empty(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk); t++;
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  int nstart;

  initial begin
    rst = 1'b1; va = 1'b0; vb = 1'b0; da = '0; db = '0; clra = 1'b0; clrb = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", ifa.tx_start, 0);
    chk("rst_tx_data", ifa.tx_data, 0);
    chk("rst_frame_sent", fsa, 0);
    chk("rst_overflow", ova, 0);
    chk("rst_level", lva, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame plus the 2-cycle start latency.
    qf(0, 7, '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h0A, 8'hBC, 8'h96}, 1'b1);
    push_a(12'h123);
    push_a(12'hABC);
    chk("lat_level", lva, 2);
    chk("lat_0", ifa.tx_start, 0);
    @(negedge clk); chk("lat_1", ifa.tx_start, 0);
    @(negedge clk); chk("lat_2", ifa.tx_start, 1);
    wait_frames(0, 1, 400);
    chk("t1_level", lva, 0);

    // A single buffered sample never starts a frame.
    push_a(12'h456);
    nstart = 0;
    repeat (1000) begin @(negedge clk); if (ifa.tx_start) nstart++; end
    chk("t2_no_start", nstart, 0);
    chk("t2_level1", lva, 1);
    qf(0, 7, '{8'hA5, 8'h02, 8'h04, 8'h56, 8'h07, 8'h89, 8'hDE}, 1'b1);
    push_a(12'h789);
    wait_frames(0, 2, 400);
    chk("t2_level0", lva, 0);

    // Overflow with the transmitter held busy; the fifth sample is dropped.
    hold_act[0] = 1'b1;
    qf(0, 7, '{8'hA5, 8'h02, 8'h01, 8'h11, 8'h02, 8'h22, 8'h32}, 1'b1);
    qf(0, 7, '{8'hA5, 8'h02, 8'h03, 8'h33, 8'h04, 8'h44, 8'h72}, 1'b1);
    @(negedge clk); va = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      da = 12'(k * 12'h111);
      @(negedge clk);
    end
    va = 1'b0;
    chk("t3_level_full", lva, 4);
    chk("t3_overflow", ova, 1);
    nstart = 0;
    repeat (50) begin @(negedge clk); if (ifa.tx_start) nstart++; end
    chk("t4_held_no_start", nstart, 0);
    @(negedge clk); clra = 1'b1;
    @(negedge clk); clra = 1'b0;
    chk("t3_clr_ovf", ova, 0);
    @(negedge clk); va = 1'b1; da = 12'h666; clra = 1'b1;
    @(negedge clk); va = 1'b0; clra = 1'b0;
    chk("t3_drop_beats_clr", ova, 1);
    chk("t3_level_kept", lva, 4);
    @(negedge clk); clra = 1'b1;
    @(negedge clk); clra = 1'b0;
    chk("t3_clr_ovf2", ova, 0);
    hold_act[0] = 1'b0;
    wait_frames(0, 4, 800);
    chk("t3_level0", lva, 0);

    // Reset during the LO byte of sample 1 while the transmitter is busy.
    qf(0, 6, '{8'hA5, 8'h02, 8'h00, 8'hF0, 8'h00, 8'hE1, 8'h00}, 1'b0);
    push_a(12'h0F0);
    push_a(12'h0E1);
    wait_sb_empty(400);
    repeat (2) @(negedge clk);
    chk("t5_busy_at_rst", ifa.tx_active, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx_start", ifa.tx_start, 0);
    chk("t5_rst_tx_data", ifa.tx_data, 0);
    chk("t5_rst_frame_sent", fsa, 0);
    chk("t5_rst_overflow", ova, 0);
    chk("t5_rst_level", lva, 0);
    @(negedge clk); rst = 1'b0;
    qf(0, 7, '{8'hA5, 8'h02, 8'h01, 8'hFF, 8'h08, 8'h00, 8'hF4}, 1'b1);
    push_a(12'h1FF);
    push_a(12'h800);
    wait_frames(0, 5, 400);
    chk("t5_level0", lva, 0);

    // 16-bit samples, one per frame.
    qf(1, 5, '{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00}, 1'b1);
    @(negedge clk); vb = 1'b1; db = 16'hFFFF;
    @(negedge clk); vb = 1'b0;
    wait_frames(1, 1, 400);
    chk("t6_level0", lvb, 0);

    repeat (20) @(negedge clk);
    chk("end_sb_empty", sb.size(), 0);
    chk("end_frames_a", frames[0], 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Sits directly upstream of the UART transmitter.
- Buffers ADC samples in a small FIFO and packs each group of FRAME_LEN samples into a byte frame: sync, length, samples as hi/lo byte pairs, checksum.
- Feeds the transmitter one byte at a time over its start/data/active/done handshake, so the host receives framed scope data.

Parameters:
- SAMPLE_W, 12, sample width in bits; legal range 9..16.
- FRAME_LEN, 16, samples per frame; legal range 1..255.
- FIFO_DEPTH, 32, sample FIFO depth; power of two, at least FRAME_LEN.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- smp_valid  in  1  sample strobe, one cycle per sample, no backpressure
- smp_data  in  SAMPLE_W  sample value
- clr_ovf  in  1  clears the overflow flag
- tx_start  out  1  one-cycle byte request to the transmitter
- tx_data  out  8  byte to send; valid while tx_start=1
- tx_active  in  1  transmitter busy
- tx_done  in  1  transmitter one-cycle byte-complete pulse
- frame_sent  out  1  one-cycle pulse after the checksum byte completes
- overflow  out  1  sticky; a sample was dropped
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values: tx_start=0, tx_data=0, frame_sent=0, overflow=0, fifo_level=0, FSM=IDLE, checksum=0.
- FIFO push: on smp_valid when not full.
- FIFO overflow: smp_valid while full drops the sample and sets overflow.
- Push and pop in the same cycle while full: the push is accepted and the level is unchanged.
- overflow clear: clr_ovf clears it. A new drop in the same cycle as clr_ovf wins, so overflow stays 1.
- FSM states:
  - IDLE: go to SYNC when fifo_level >= FRAME_LEN and tx_active=0.
  - SYNC: sends SYNC_BYTE.
  - LEN: sends FRAME_LEN[7:0].
  - HI: pops the FIFO head; sends zero-extended smp[SAMPLE_W-1:8]. The low byte is held in a register.
  - LO: sends the held smp[7:0].
  - HI/LO repeat FRAME_LEN times, tracked by an 8-bit sample counter.
  - CSUM: sends the checksum.
  - Back to IDLE.
- Byte issue, in every sending state:
  - Sub-phase ISSUE: tx_start=1 for exactly one cycle with tx_data stable. Issued only when tx_active=0.
  - Sub-phase WAIT: hold until tx_done=1.
  - Advance on the cycle after tx_done. The next ISSUE therefore lands no earlier than one cycle after done.
- Checksum: 8-bit XOR of every byte after SYNC (LEN, all HI, all LO). Cleared in IDLE.
- frame_sent: pulses on the cycle the CSUM tx_done is seen.
- No partial frames: a frame starts only when FRAME_LEN samples are already buffered. The FIFO keeps filling during transmission.
- tx_done outside WAIT is ignored.
- Reset mid-frame:
  - Everything clears and the FIFO is emptied.
  - The transmitter is not reset, so the IDLE entry condition (tx_active=0) prevents start collisions.
  - A stray tx_done after reset is ignored.
- Latency: with FIFO already holding FRAME_LEN samples and tx_active=0, tx_start for SYNC asserts 2 cycles after the FIFO reaches FRAME_LEN (level register, then FSM).

Decomposition:
- Package uart_frame_pkg:
  - FSM state enum (IDLE, SYNC, LEN, HI, LO, CSUM).
  - Byte sub-phase enum (ISSUE, WAIT).
  - Default SYNC_BYTE constant.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout, full, empty, level.
  - dout is first-word-fall-through.
  - Implements the push-while-full-with-pop rule.
- Framing FSM, checksum and counters live in uart_frame_tx.

Test Plan:
1. FRAME_LEN=2; push 0x123, 0xABC; bench model of transmitter (done 10 cycles after start) -> bytes A5, 02, 01, 23, 0A, BC, 96; one frame_sent pulse after the 96 byte.
2. Push 1 sample with FRAME_LEN=2 -> no tx_start for 1000 cycles. Push a 2nd sample -> frame starts; fifo_level returns to 0 after both pops.
3. FIFO_DEPTH=4; 5 back-to-back smp_valid while the transmitter is held active -> fifo_level=4, overflow=1, 5th sample absent from the frame. clr_ovf -> overflow=0.
4. Hold tx_active=1 when a frame becomes ready -> tx_start stays 0 until tx_active falls. Each byte shows exactly one tx_start pulse and no start before the prior done.
5. Assert rst during the LO byte of sample 1 while tx_active=1 -> all outputs 0 immediately. No tx_start until tx_active=0 and a fresh FRAME_LEN samples are buffered; the stray tx_done is ignored.
6. SAMPLE_W=16, FRAME_LEN=1, sample 0xFFFF -> bytes A5, 01, FF, FF, 01.
